// File: rtl/rv32i_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_program_loader_if
//  Description : Bundles the byte-stream handshake feeding the program loader
//                and the instruction-memory write port it drives.
//                  byte_valid / byte_data / byte_ready : byte stream in
//                  imem_we / imem_addr / imem_wdata    : imem write port out
//                Modport "slave" is the loader's view; "master" is the view
//                of whoever sources bytes and observes the memory writes.
//  Revision    : 1.0  initial release
// ============================================================================
interface rv32i_program_loader_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 32
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [W-1:0]      imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_program_loader
//  Description : Boot-time loader placed in front of the RV32I instruction
//                memory. Collects a little-endian byte stream into W-bit
//                instruction words, writes each non-zero word to byte address
//                word_count*INC, and keeps the core in reset until a zero
//                word (terminator) arrives or DEPTH words have been written.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous, active-low reset
//                start      - begin a new load (honoured in IDLE or DONE)
//                bus        - slave modport: byte stream in, imem write out
//                cpu_rst    - active-low core reset, 1 only in DONE
//                busy       - loader is collecting or writing
//                done       - program loaded, core released
//                word_count - instruction words written in this load
//                overflow   - DEPTH words written without a terminator
//  Revision    : 1.0  initial release
// ============================================================================
module rv32i_program_loader #(
    parameter int W      = 32,
    parameter int DEPTH  = 100,
    parameter int INC    = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    rv32i_program_loader_if.slave bus,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      word_count,
    output logic                  overflow
);

    localparam int LANES  = W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   lane, lane_nxt;
    logic [W-1:0]        asm_word, asm_nxt;
    logic [W-1:0]        word_merged;
    logic                accept;
    logic                last_lane;
    logic [CNT_W-1:0]    count_inc;

    // Registered output copies and their next values
    logic                byte_ready_q, byte_ready_nxt;
    logic                imem_we_q, imem_we_nxt;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_nxt;
    logic [W-1:0]        imem_wdata_q, imem_wdata_nxt;
    logic                cpu_rst_q, cpu_rst_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic [CNT_W-1:0]    word_count_q, word_count_nxt;
    logic                overflow_q, overflow_nxt;

    // byte_ready is a register that is only ever 1 in COLLECT, so it alone
    // qualifies the handshake; the state term keeps the intent explicit.
    assign accept    = (state == ST_COLLECT) && bus.byte_valid && byte_ready_q;
    assign last_lane = (lane == LANE_W'(LANES - 1));
    assign count_inc = word_count_q + 1'b1;

    // Assembly register with the byte currently on the bus dropped into its
    // lane; used so the complete word is known on the last handshake edge and
    // the write strobe can be registered for the very next cycle.
    always_comb begin
        word_merged = asm_word;
        word_merged[{lane, 3'b000} +: 8] = bus.byte_data;
    end

    always_comb begin
        state_nxt      = state;
        lane_nxt       = lane;
        asm_nxt        = asm_word;
        imem_we_nxt    = 1'b0;
        imem_addr_nxt  = imem_addr_q;
        imem_wdata_nxt = imem_wdata_q;
        word_count_nxt = word_count_q;
        overflow_nxt   = overflow_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt      = ST_COLLECT;
                    lane_nxt       = '0;
                    asm_nxt        = '0;
                    word_count_nxt = '0;
                    overflow_nxt   = 1'b0;
                end
            end

            ST_COLLECT: begin
                if (accept) begin
                    asm_nxt = word_merged;
                    if (last_lane) begin
                        lane_nxt  = '0;
                        state_nxt = ST_WRITE;
                        // A zero word is the terminator and never reaches memory.
                        if (word_merged != '0) begin
                            imem_we_nxt    = 1'b1;
                            imem_addr_nxt  = ADDR_W'(word_count_q) * ADDR_W'(INC);
                            imem_wdata_nxt = word_merged;
                        end
                    end else begin
                        lane_nxt = lane + 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (asm_word == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    word_count_nxt = count_inc;
                    if (count_inc == CNT_W'(DEPTH)) begin
                        overflow_nxt = 1'b1;
                        state_nxt    = ST_DONE;
                    end else begin
                        state_nxt = ST_COLLECT;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_nxt      = ST_COLLECT;
                    lane_nxt       = '0;
                    asm_nxt        = '0;
                    word_count_nxt = '0;
                    overflow_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the next state.
        byte_ready_nxt = (state_nxt == ST_COLLECT);
        busy_nxt       = (state_nxt == ST_COLLECT) || (state_nxt == ST_WRITE);
        done_nxt       = (state_nxt == ST_DONE);
        cpu_rst_nxt    = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            lane         <= '0;
            asm_word     <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            lane         <= lane_nxt;
            asm_word     <= asm_nxt;
            byte_ready_q <= byte_ready_nxt;
            imem_we_q    <= imem_we_nxt;
            imem_addr_q  <= imem_addr_nxt;
            imem_wdata_q <= imem_wdata_nxt;
            cpu_rst_q    <= cpu_rst_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            word_count_q <= word_count_nxt;
            overflow_q   <= overflow_nxt;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign word_count     = word_count_q;
    assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_program_loader
//  Description : Self-checking bench for rv32i_program_loader (DEPTH=4).
//                A per-cycle reference model predicts memory writes, word
//                count and overflow from the observed byte handshakes;
//                directed scenarios pin the model with literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32i_program_loader;

    localparam int W      = 32;
    localparam int DEPTH  = 4;
    localparam int INC    = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             cpu_rst;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] word_count;
    logic             overflow;

    rv32i_program_loader_if #(.W(W), .ADDR_W(ADDR_W)) bus ();

    rv32i_program_loader #(
        .W(W), .DEPTH(DEPTH), .INC(INC), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writes observed on the memory port, in order
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    // ---------------- reference model + per-cycle compare ----------------
    int          m_lane = 0;
    logic [31:0] m_word = '0;
    int          m_wc   = 0;
    logic        m_ovf  = 1'b0;
    logic        m_we   = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_flags",
                64'({bus.byte_ready, bus.imem_we, cpu_rst, busy, done, overflow, word_count}), 64'(0));
            chk("reset_addr",  64'(bus.imem_addr),  64'(0));
            chk("reset_wdata", 64'(bus.imem_wdata), 64'(0));
            m_lane = 0; m_wc = 0; m_ovf = 1'b0; m_we = 1'b0;
        end else begin
            chk("imem_we", 64'(bus.imem_we), 64'(m_we));
            if (bus.imem_we && m_we) begin
                chk("imem_addr",  64'(bus.imem_addr),  64'(m_addr));
                chk("imem_wdata", 64'(bus.imem_wdata), 64'(m_data));
                log_addr.push_back(bus.imem_addr);
                log_data.push_back(bus.imem_wdata);
            end
            chk("cpu_rst_vs_done", 64'(cpu_rst), 64'(done));
            if (bus.imem_we) chk("ready_low_in_write", 64'(bus.byte_ready), 64'(0));
            if (done) chk("done_quiet", 64'({busy, bus.byte_ready}), 64'(0));
            chk("word_count", 64'(word_count), 64'(m_wc));
            chk("overflow",   64'(overflow),   64'(m_ovf));

            // advance model to next cycle
            if (m_we) begin
                m_wc++;
                if (m_wc == DEPTH) m_ovf = 1'b1;
            end
            m_we = 1'b0;
            if (bus.byte_valid && bus.byte_ready) begin
                m_word[8*m_lane +: 8] = bus.byte_data;
                m_lane++;
                if (m_lane == W/8) begin
                    m_lane = 0;
                    if (m_word != 32'h0) begin
                        m_we   = 1'b1;
                        m_addr = m_wc * INC;
                        m_data = m_word;
                    end
                end
            end
            if (!busy && start) begin
                m_wc = 0; m_ovf = 1'b0; m_lane = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit hs;
        int n;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.byte_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk("byte_accept_timeout", 64'(0), 64'(1));
    endtask

    // maxgap < 0 : valid held high; otherwise random idle gap 0..maxgap
    task automatic send_words(input logic [31:0] words[$], input int maxgap);
        logic [31:0] w;
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int k = 0; k < W/8; k++) begin
                send_byte(w[8*k +: 8], (maxgap < 0) ? 0 : int'($urandom_range(0, maxgap)));
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_reached", 64'(done), 64'(1));
    endtask

    task automatic check_log(input string name, input int base,
                             input logic [31:0] ea[$], input logic [31:0] ed[$]);
        chk({name, "_count"}, 64'(log_addr.size() - base), 64'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (base + i < log_addr.size()) begin
                chk({name, "_addr"}, 64'(log_addr[base+i]), 64'(ea[i]));
                chk({name, "_data"}, 64'(log_data[base+i]), 64'(ed[i]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // reset state
        repeat (2) tick();
        chk("rst_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("rst_done",    64'(done),    64'(0));
        rst = 1'b1;
        tick();
        chk("idle_ready", 64'(bus.byte_ready), 64'(0));
        chk("idle_cpu_rst", 64'(cpu_rst), 64'(0));

        // scenario 1: three instructions + terminator, one idle cycle per byte
        base = log_addr.size();
        do_start();
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_ready", 64'(bus.byte_ready), 64'(1));
        send_words('{32'h00500093, 32'h00300113, 32'h002081B3, 32'h0}, 1);
        wait_done();
        check_log("s1", base, '{32'd0, 32'd4, 32'd8},
                  '{32'h00500093, 32'h00300113, 32'h002081B3});
        chk("s1_wc",   64'(word_count), 64'(3));
        chk("s1_ovf",  64'(overflow),   64'(0));
        chk("s1_cpu",  64'(cpu_rst),    64'(1));

        // scenario 2a: valid held high (WRITE cycles stall the offered byte)
        base = log_addr.size();
        do_start();
        send_words('{32'h00500093, 32'h00300113, 32'h002081B3, 32'h0}, -1);
        wait_done();
        check_log("s2a", base, '{32'd0, 32'd4, 32'd8},
                  '{32'h00500093, 32'h00300113, 32'h002081B3});
        chk("s2a_wc", 64'(word_count), 64'(3));

        // scenario 2b: random valid gaps
        base = log_addr.size();
        do_start();
        send_words('{32'h00500093, 32'h00300113, 32'h002081B3, 32'h0}, 3);
        wait_done();
        check_log("s2b", base, '{32'd0, 32'd4, 32'd8},
                  '{32'h00500093, 32'h00300113, 32'h002081B3});
        chk("s2b_wc", 64'(word_count), 64'(3));

        // scenario 3: DEPTH words without terminator -> overflow
        base = log_addr.size();
        do_start();
        send_words('{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 0);
        wait_done();
        check_log("s3", base, '{32'd0, 32'd4, 32'd8, 32'd12},
                  '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
        chk("s3_ovf", 64'(overflow),   64'(1));
        chk("s3_wc",  64'(word_count), 64'(4));
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_no_accept", 64'(bus.byte_ready), 64'(0));
        end
        tick();
        bus.byte_valid = 1'b0;
        chk("s3_no_extra_write", 64'(log_addr.size() - base), 64'(4));

        // scenario 5: restart from DONE
        base = log_addr.size();
        do_start();
        chk("s5_cpu_rst", 64'(cpu_rst),    64'(0));
        chk("s5_done",    64'(done),       64'(0));
        chk("s5_wc",      64'(word_count), 64'(0));
        chk("s5_ovf",     64'(overflow),   64'(0));
        send_words('{32'hDEADBEEF, 32'h0}, 0);
        wait_done();
        check_log("s5", base, '{32'd0}, '{32'hDEADBEEF});
        chk("s5_wc_end", 64'(word_count), 64'(1));

        // scenario 6: immediate terminator
        base = log_addr.size();
        do_start();
        send_words('{32'h0}, 0);
        wait_done();
        chk("s6_writes", 64'(log_addr.size() - base), 64'(0));
        chk("s6_wc",     64'(word_count), 64'(0));
        chk("s6_cpu",    64'(cpu_rst),    64'(1));

        // scenario 4: reset mid-load, then reload
        base = log_addr.size();
        do_start();
        send_words('{32'hA1A2A3A4, 32'hB1B2B3B4}, 0);
        send_byte(8'hC4, 0);
        send_byte(8'hC3, 0);
        rst = 1'b0;
        #1;
        chk("s4_async_flags",
            64'({bus.byte_ready, bus.imem_we, cpu_rst, busy, done, overflow, word_count}), 64'(0));
        chk("s4_async_addr",  64'(bus.imem_addr),  64'(0));
        chk("s4_async_wdata", 64'(bus.imem_wdata), 64'(0));
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        chk("s4_writes_before", 64'(log_addr.size() - base), 64'(2));
        rst = 1'b1;
        tick();
        base = log_addr.size();
        do_start();
        send_words('{32'h00A00513, 32'h0}, 0);
        wait_done();
        check_log("s4", base, '{32'd0}, '{32'h00A00513});
        chk("s4_wc", 64'(word_count), 64'(1));

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
